// File: rtl/player_shot.sv
// Player-cannon shot generator: launches one bullet on a fire press, steps it up
// one row per speed tick, retires it on a hit edge or at the top, then reloads.
module player_shot #(
    parameter int SPEED     = 36000,
    parameter int COOLDOWN  = 4,
    parameter int START_ROW = 14
) (
    input  logic       i_clk_36MHz,
    input  logic       i_reset,
    input  logic       i_fire,
    input  logic [4:0] i_player_x,
    input  logic       i_hit,
    output logic [4:0] o_bullet_x,
    output logic [3:0] o_bullet_y,
    output logic       o_bullet_active,
    output logic       o_ready,
    output logic [7:0] o_hit_count
);

    localparam int CNT_W = (SPEED > 1) ? $clog2(SPEED) : 1;
    localparam int CD_W  = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [CNT_W-1:0] SPEED_LAST = CNT_W'(SPEED - 1);
    localparam logic [CD_W-1:0]  CD_LAST    = CD_W'(COOLDOWN - 1);
    localparam logic [3:0]       START_Y    = 4'(START_ROW);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FLYING   = 2'd1,
        S_COOLDOWN = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CD_W-1:0]  cd_cnt, cd_cnt_n;
    logic             fire_d, hit_d;
    logic             fire_edge, hit_edge, tick;
    logic [4:0]       bullet_x_n;
    logic [3:0]       bullet_y_n;
    logic             bullet_active_n, ready_n;
    logic [7:0]       hit_count_n;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign fire_edge = i_fire & ~fire_d;
    assign hit_edge  = i_hit & ~hit_d;
    assign tick      = (cnt == SPEED_LAST);

    always_ff @(posedge i_clk_36MHz or posedge i_reset) begin
        if (i_reset) begin
            state           <= S_IDLE;
            cnt             <= '0;
            cd_cnt          <= '0;
            fire_d          <= 1'b0;
            hit_d           <= 1'b0;
            o_bullet_x      <= 5'd0;
            o_bullet_y      <= 4'd0;
            o_bullet_active <= 1'b0;
            o_ready         <= 1'b1;
            o_hit_count     <= 8'd0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            cd_cnt          <= cd_cnt_n;
            fire_d          <= i_fire;
            hit_d           <= i_hit;
            o_bullet_x      <= bullet_x_n;
            o_bullet_y      <= bullet_y_n;
            o_bullet_active <= bullet_active_n;
            o_ready         <= ready_n;
            o_hit_count     <= hit_count_n;
        end
    end

    always_comb begin
        state_n         = state;
        cd_cnt_n        = cd_cnt;
        bullet_x_n      = o_bullet_x;
        bullet_y_n      = o_bullet_y;
        bullet_active_n = o_bullet_active;
        ready_n         = o_ready;
        hit_count_n     = o_hit_count;

        case (state)
            S_IDLE: begin
                ready_n         = 1'b1;
                bullet_active_n = 1'b0;
                bullet_y_n      = 4'd0;
                cd_cnt_n        = '0;
                if (fire_edge) begin
                    bullet_x_n      = i_player_x;
                    bullet_y_n      = START_Y;
                    bullet_active_n = 1'b1;
                    ready_n         = 1'b0;
                    state_n         = S_FLYING;
                end
            end
            S_FLYING: begin
                ready_n  = 1'b0;
                cd_cnt_n = '0;
                // A hit wins over a simultaneous step so the bullet never moves past its target
                if (hit_edge) begin
                    hit_count_n     = sat_inc(o_hit_count);
                    bullet_y_n      = 4'd0;
                    bullet_active_n = 1'b0;
                    state_n         = S_COOLDOWN;
                end else if (tick) begin
                    if (o_bullet_y > 4'd1) begin
                        bullet_y_n = o_bullet_y - 4'd1;
                    end else begin
                        bullet_y_n      = 4'd0;
                        bullet_active_n = 1'b0;
                        state_n         = S_COOLDOWN;
                    end
                end
            end
            S_COOLDOWN: begin
                bullet_y_n      = 4'd0;
                bullet_active_n = 1'b0;
                ready_n         = 1'b0;
                if (tick) begin
                    if (cd_cnt == CD_LAST) begin
                        cd_cnt_n = '0;
                        ready_n  = 1'b1;
                        state_n  = S_IDLE;
                    end else begin
                        cd_cnt_n = cd_cnt + 1'b1;
                    end
                end
            end
            default: begin
                bullet_y_n      = 4'd0;
                bullet_active_n = 1'b0;
                ready_n         = 1'b1;
                cd_cnt_n        = '0;
                state_n         = S_IDLE;
            end
        endcase

        // Tick phase restarts on every state change so each state sees a full period first
        if (state_n != state || state == S_IDLE || tick) begin
            cnt_n = '0;
        end else begin
            cnt_n = cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_player_shot.sv
// Directed bench for player_shot with SPEED=4, COOLDOWN=2, START_ROW=14.
module tb_player_shot;

    logic       clk = 1'b0;
    logic       rst;
    logic       fire;
    logic [4:0] player_x;
    logic       hit;
    logic [4:0] bullet_x;
    logic [3:0] bullet_y;
    logic       bullet_active;
    logic       ready;
    logic [7:0] hit_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    player_shot #(.SPEED(4), .COOLDOWN(2), .START_ROW(14)) dut (
        .i_clk_36MHz    (clk),
        .i_reset        (rst),
        .i_fire         (fire),
        .i_player_x     (player_x),
        .i_hit          (hit),
        .o_bullet_x     (bullet_x),
        .o_bullet_y     (bullet_y),
        .o_bullet_active(bullet_active),
        .o_ready        (ready),
        .o_hit_count    (hit_count)
    );

    // Advance one clock; inputs and samples both sit 1 time unit after the rising edge.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; fire = 1'b0; hit = 1'b0; player_x = 5'd0;
        step(2);
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready); end
        n_checks++; if (bullet_y !== 4'd0) begin n_fail++; $display("FAIL reset_y got %0d want 0", bullet_y); end
        n_checks++; if (hit_count !== 8'd0) begin n_fail++; $display("FAIL reset_hits got %0d want 0", hit_count); end
        rst = 1'b0;
        step(2);
        player_x = 5'd7; fire = 1'b1;
        step();
        fire = 1'b0;
        n_checks++; if (bullet_active !== 1'b1) begin n_fail++; $display("FAIL rst_launch_active got %b want 1", bullet_active); end
        step(12);
        n_checks++; if (bullet_y !== 4'd11) begin n_fail++; $display("FAIL rst_3ticks_y got %0d want 11", bullet_y); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bullet_x !== 5'd0) begin n_fail++; $display("FAIL midflight_rst_x got %0d want 0", bullet_x); end
        n_checks++; if (bullet_y !== 4'd0) begin n_fail++; $display("FAIL midflight_rst_y got %0d want 0", bullet_y); end
        n_checks++; if (bullet_active !== 1'b0) begin n_fail++; $display("FAIL midflight_rst_active got %b want 0", bullet_active); end
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL midflight_rst_ready got %b want 1", ready); end
        n_checks++; if (hit_count !== 8'd0) begin n_fail++; $display("FAIL midflight_rst_hits got %0d want 0", hit_count); end
        step();
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_miss();
        player_x = 5'd7; fire = 1'b1;
        step();
        fire = 1'b0;
        n_checks++; if (bullet_y !== 4'd14) begin n_fail++; $display("FAIL miss_launch_y got %0d want 14", bullet_y); end
        n_checks++; if (bullet_x !== 5'd7) begin n_fail++; $display("FAIL miss_launch_x got %0d want 7", bullet_x); end
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL miss_launch_ready got %b want 0", ready); end
        player_x = 5'd19;
        step(3);
        n_checks++; if (bullet_y !== 4'd14) begin n_fail++; $display("FAIL miss_pre_tick_y got %0d want 14", bullet_y); end
        step();
        for (int k = 1; k <= 13; k++) begin
            n_checks++; if (bullet_y !== 4'(14 - k)) begin n_fail++; $display("FAIL miss_tick%0d_y got %0d want %0d", k, bullet_y, 14 - k); end
            step(4);
        end
        n_checks++; if (bullet_y !== 4'd0) begin n_fail++; $display("FAIL miss_top_y got %0d want 0", bullet_y); end
        n_checks++; if (bullet_active !== 1'b0) begin n_fail++; $display("FAIL miss_top_active got %b want 0", bullet_active); end
        n_checks++; if (bullet_x !== 5'd7) begin n_fail++; $display("FAIL miss_x_held got %0d want 7", bullet_x); end
        step(7);
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL miss_cool7_ready got %b want 0", ready); end
        step();
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL miss_cool8_ready got %b want 1", ready); end
        n_checks++; if (hit_count !== 8'd0) begin n_fail++; $display("FAIL miss_hits got %0d want 0", hit_count); end
    endtask

    // Covers the held hit (no double count across retire and relaunch) and a hit landing on a tick.
    task automatic test_hit();
        player_x = 5'd3; fire = 1'b1;
        step();
        fire = 1'b0;
        step(20);
        n_checks++; if (bullet_y !== 4'd9) begin n_fail++; $display("FAIL hit_5ticks_y got %0d want 9", bullet_y); end
        hit = 1'b1;
        step();
        n_checks++; if (bullet_y !== 4'd0) begin n_fail++; $display("FAIL hit_retire_y got %0d want 0", bullet_y); end
        n_checks++; if (bullet_active !== 1'b0) begin n_fail++; $display("FAIL hit_retire_active got %b want 0", bullet_active); end
        n_checks++; if (hit_count !== 8'd1) begin n_fail++; $display("FAIL hit_count1 got %0d want 1", hit_count); end
        step(8);
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL hit_cool_ready got %b want 1", ready); end
        player_x = 5'd10; fire = 1'b1;
        step();
        fire = 1'b0;
        n_checks++; if (bullet_active !== 1'b1) begin n_fail++; $display("FAIL held_hit_relaunch got %b want 1", bullet_active); end
        step(10);
        hit = 1'b0;
        n_checks++; if (hit_count !== 8'd1) begin n_fail++; $display("FAIL held_hit_count got %0d want 1", hit_count); end
        n_checks++; if (bullet_y !== 4'd12) begin n_fail++; $display("FAIL held_hit_y got %0d want 12", bullet_y); end
        step();
        hit = 1'b1;
        step();
        hit = 1'b0;
        n_checks++; if (bullet_y !== 4'd0) begin n_fail++; $display("FAIL hit_on_tick_y got %0d want 0", bullet_y); end
        n_checks++; if (hit_count !== 8'd2) begin n_fail++; $display("FAIL hit_on_tick_count got %0d want 2", hit_count); end
        step(8);
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL hit_on_tick_ready got %b want 1", ready); end
    endtask

    task automatic test_fire_held();
        player_x = 5'd5; fire = 1'b1;
        step();
        n_checks++; if (bullet_x !== 5'd5) begin n_fail++; $display("FAIL held_launch_x got %0d want 5", bullet_x); end
        step(56 + 8 + 3);
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL held_idle_ready got %b want 1", ready); end
        n_checks++; if (bullet_active !== 1'b0) begin n_fail++; $display("FAIL held_no_autofire got %b want 0", bullet_active); end
        fire = 1'b0;
        step();
        player_x = 5'd12; fire = 1'b1;
        step();
        fire = 1'b0;
        n_checks++; if (bullet_active !== 1'b1) begin n_fail++; $display("FAIL repress_active got %b want 1", bullet_active); end
        n_checks++; if (bullet_x !== 5'd12) begin n_fail++; $display("FAIL repress_x got %0d want 12", bullet_x); end
        n_checks++; if (bullet_y !== 4'd14) begin n_fail++; $display("FAIL repress_y got %0d want 14", bullet_y); end
        hit = 1'b1;
        step();
        hit = 1'b0;
        n_checks++; if (hit_count !== 8'd3) begin n_fail++; $display("FAIL repress_hit_count got %0d want 3", hit_count); end
        step(8);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 260; i++) begin
            fire = 1'b1;
            step();
            fire = 1'b0; hit = 1'b1;
            step();
            hit = 1'b0;
            if (i == 0) begin
                n_checks++; if (hit_count !== 8'd4) begin n_fail++; $display("FAIL sat_first got %0d want 4", hit_count); end
            end
            if (i == 251) begin
                n_checks++; if (hit_count !== 8'd255) begin n_fail++; $display("FAIL sat_reach got %0d want 255", hit_count); end
            end
            step(8);
        end
        n_checks++; if (hit_count !== 8'd255) begin n_fail++; $display("FAIL sat_hold got %0d want 255", hit_count); end
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL sat_ready got %b want 1", ready); end
    endtask

    initial begin
        test_reset();
        test_miss();
        test_hit();
        test_fire_held();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/player_shot.md
Name: player_shot

Overview:
- Player-cannon shot generator: the bullet side of the bullet/invader hit interface.
- On a fire press it launches one bullet from the player's column and steps it upward one row per speed tick.
- It drives bullet_x/bullet_y into the invader formation block and retires the bullet on the formation's hit flag or on reaching the top.
- It enforces a reload cooldown and keeps a saturating hit counter for the score/display logic.

Parameters:
SPEED, 36000, clock cycles per bullet step (tick period); must be >= 1
COOLDOWN, 4, ticks spent in reload after a bullet retires; must be >= 1
START_ROW, 14, row loaded into o_bullet_y at launch (1..15)

Ports:
i_clk_36MHz  input  1  system clock
i_reset  input  1  asynchronous, active-high reset
i_fire  input  1  fire button level, already synchronised to i_clk_36MHz
i_player_x  input  5  player cannon column, 0..19
i_hit  input  1  hit flag from invader formation; may stay high for many cycles
o_bullet_x  output  5  bullet column
o_bullet_y  output  4  bullet row; 0 = no bullet (off-field)
o_bullet_active  output  1  bullet in flight
o_ready  output  1  high in IDLE (cannon loaded)
o_hit_count  output  8  invaders destroyed, saturating

Behaviour:
- Reset (async, active-high):
  - state IDLE; o_bullet_x=0, o_bullet_y=0, o_bullet_active=0, o_ready=1, o_hit_count=0.
  - Tick counter, cooldown counter, fire_d and hit_d all cleared.
  - Reset takes effect immediately, including mid-flight; no bullet survives reset.
- Edge detect (fire_d/hit_d register the previous i_fire/i_hit every cycle):
  - fire_edge = i_fire & ~fire_d
  - hit_edge = i_hit & ~hit_d
- Tick:
  - Counter runs 0..SPEED-1 only in FLYING and COOLDOWN; tick = (cnt == SPEED-1), then cnt wraps to 0.
  - cnt is forced to 0 on every state change and held at 0 in IDLE.
  - The first tick after entering a state therefore comes SPEED cycles later.
- IDLE:
  - o_ready=1, o_bullet_active=0, o_bullet_y=0.
  - On fire_edge: at the same clock edge latch o_bullet_x=i_player_x, set o_bullet_y=START_ROW, o_bullet_active=1, o_ready=0, go to FLYING. Latency is 1 cycle from fire_edge to outputs.
  - Fire held high does not autofire; release and press again are required.
- FLYING:
  - o_bullet_x is constant for the whole flight; i_player_x changes are ignored.
  - hit_edge has priority over tick in the same cycle: o_hit_count += 1 (saturate at 255), o_bullet_y=0, o_bullet_active=0, go to COOLDOWN.
  - Else on tick with o_bullet_y > 1: o_bullet_y decrements by 1.
  - Else on tick with o_bullet_y == 1 (top reached, miss): o_bullet_y=0, o_bullet_active=0, go to COOLDOWN. o_hit_count is unchanged.
  - fire_edge is ignored (not queued).
- COOLDOWN:
  - o_bullet_y=0, o_bullet_active=0, o_ready=0.
  - Counts COOLDOWN ticks; on the COOLDOWN-th tick go to IDLE (o_ready=1 next cycle).
  - fire_edge and hit_edge are ignored; hit_d is still updated every cycle.
- Level-high i_hit:
  - A level-high i_hit spanning the retire and the next launch does not count again.
  - Only a fresh rising edge while in FLYING counts.
- State encoding: 2-bit; the unused code recovers to IDLE on the next clock.
- All outputs are registered.

Test Plan:
1. Reset mid-flight (SPEED=4, COOLDOWN=2, START_ROW=14): fire at x=7, assert i_reset after 3 ticks -> outputs immediately x=0, y=0, active=0, ready=1, hit_count=0.
2. Full miss: fire 1-cycle pulse, i_player_x=7 -> next cycle y=14, x=7, active=1. y decrements every 4 cycles to 1; the 14th tick gives y=0, active=0. Exactly 8 cycles later ready=1. hit_count stays 0.
3. Hit mid-flight: fire at x=3. After 5 ticks (y=9), raise i_hit and hold it high 20 cycles -> next cycle y=0, active=0, hit_count=1. The held hit does not increment again.
4. Hit and tick in the same cycle: i_hit rises exactly on a tick cycle -> bullet retires (y=0), hit_count +1, no decrement observed.
5. Fire held high through flight and cooldown -> no relaunch. Release and re-press in IDLE -> launch with the new i_player_x.
6. Saturation: 260 hit-retired shots -> o_hit_count stays 255.
